// File: rtl/lod8_arb_pkg.sv
// Shared types and helpers for the lod8-based round-robin arbiter.
// The request width, id width, FSM encoding and the "below index" mask live here.
package lod8_arb_pkg;

    localparam int NREQ = 8;
    localparam int IDW  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_LO,
        SCAN_ALL,
        GRANT
    } arb_state_t;

    // Bits strictly below index k; below_mask(0) is empty.
    function automatic logic [NREQ-1:0] below_mask(input logic [IDW-1:0] k);
        return (NREQ'(1) << k) - NREQ'(1);
    endfunction

endpackage

// File: rtl/lod8_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface lod8_rr_arbiter_if;
    import lod8_arb_pkg::*;

    logic [NREQ-1:0] rx_req;
    logic            rx_release;
    logic            tx_grant_valid;
    logic [IDW-1:0]  tx_grant_id;
    logic [NREQ-1:0] tx_grant_onehot;
    logic            tx_timeout;
    logic            tx_busy;

    modport master (
        output rx_req, rx_release,
        input  tx_grant_valid, tx_grant_id, tx_grant_onehot, tx_timeout, tx_busy
    );

    modport slave (
        input  rx_req, rx_release,
        output tx_grant_valid, tx_grant_id, tx_grant_onehot, tx_timeout, tx_busy
    );

endinterface

// File: rtl/lod8_rr_arbiter_lod8.sv
// Leading-one detector for 8 bits: reports the highest set index when enabled,
// and holds its last result while disabled.
module lod8
    import lod8_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_enable,
    input  logic [NREQ-1:0] rx_data,
    output logic [IDW-1:0]  tx_data,
    output logic            tx_hotflag
);

    logic [IDW-1:0] w_idx;
    logic           w_hot;
    logic [IDW-1:0] r_idx;
    logic           r_hot;

    // NOTE: every always_comb output gets a default first, otherwise an
    // incomplete assignment path infers a latch.
    always_comb begin
        w_idx = '0;
        w_hot = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rx_data[i]) begin
                w_idx = IDW'(i);
                w_hot = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_hot <= 1'b0;
        end else if (rx_enable) begin
            r_idx <= w_idx;
            r_hot <= w_hot;
        end
    end

    assign tx_data    = rx_enable ? w_idx : r_idx;
    assign tx_hotflag = rx_enable ? w_hot : r_hot;

endmodule

// File: rtl/lod8_rr_arbiter.sv
// Round-robin arbiter for 8 requesters: scans below the last winner first, then
// all requests, using one shared lod8. Grants end on release, abandon or timeout.
module lod8_rr_arbiter
    import lod8_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic              aclk,
    input  logic              areset,
    lod8_rr_arbiter_if.slave  bus
);

    localparam int CNTW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_req_q;
    logic [IDW-1:0]  r_grant_id;
    logic [CNTW-1:0] r_cnt;
    logic            r_timeout;

    logic [NREQ-1:0] w_lod_in;
    logic            w_lod_en;
    logic [IDW-1:0]  w_lod_idx;
    logic            w_lod_hot;
    logic            w_abandon;
    logic            w_hold_exp;
    logic            w_exit;
    logic            w_force;

    assign w_lod_en = (r_state == SCAN_LO) || (r_state == SCAN_ALL);
    assign w_lod_in = (r_state == SCAN_LO) ? (r_req_q & below_mask(r_ptr)) : r_req_q;

    lod8 u_lod (
        .clk        (aclk),
        .rst_n      (~areset),
        .rx_enable  (w_lod_en),
        .rx_data    (w_lod_in),
        .tx_data    (w_lod_idx),
        .tx_hotflag (w_lod_hot)
    );

    // Release outranks abandon, which outranks timeout; a forced release only
    // reports tx_timeout when neither of the others is present.
    assign w_abandon  = ~bus.rx_req[r_grant_id];
    assign w_hold_exp = (HOLD_MAX != 0) && (int'(r_cnt) == HOLD_MAX - 1);
    assign w_exit     = bus.rx_release | w_abandon | w_hold_exp;
    assign w_force    = w_hold_exp & ~bus.rx_release & ~w_abandon;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (|bus.rx_req) w_next = SCAN_LO;
            SCAN_LO:  w_next = w_lod_hot ? GRANT : SCAN_ALL;
            SCAN_ALL: w_next = w_lod_hot ? GRANT : IDLE;
            GRANT:    if (w_exit) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_req_q    <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|bus.rx_req) r_req_q <= bus.rx_req;
                end
                SCAN_LO, SCAN_ALL: begin
                    if (w_lod_hot) r_grant_id <= w_lod_idx;
                end
                GRANT: begin
                    if (w_exit) begin
                        r_ptr     <= r_grant_id;
                        r_cnt     <= '0;
                        r_timeout <= w_force;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_grant_valid  = (r_state == GRANT);
    assign bus.tx_grant_id     = r_grant_id;
    assign bus.tx_grant_onehot = (r_state == GRANT) ? (NREQ'(1) << r_grant_id) : '0;
    assign bus.tx_timeout      = r_timeout;
    assign bus.tx_busy         = (r_state != IDLE);

endmodule
